orbit_index_ctrl: RTL
=====================

# orbit_index_ctrl

Keyboard-to-angle controller that sits directly upstream of the ball stage. It samples the keycode once per video frame and keeps the shared angular index of the two orbiting balls on the 60-position circle. Red starts at 0 and blue is always diametrically opposite. Key-hold auto-repeat gives a slow start and then full-rate rotation. The `red_index`/`blue_index` outputs drive the `index` input of the red and blue ball instances.

## Interface
- `STEPS`, 60: positions on the circle; indices span 0..STEPS-1.
- `HALF`, 30: offset of blue from red (STEPS/2).
- `SLOW_DIV`, 4: frames per step during the slow phase (≥1).
- `HOLD_FRAMES`, 12: frames held in the slow phase before switching to the fast phase (≥1).
- `KEY_CCW`, 8'd4: left key; rotates counter-clockwise (index +1).
- `KEY_CW`, 8'd7: right key; rotates clockwise (index −1).

- `Clk`  in  1  system clock (50 MHz); the only clock.
- `Reset`  in  1  synchronous, active-low reset.
- `frame_clk`  in  1  raw frame strobe from the VGA controller; not used as a clock.
- `enable`  in  1  game active; when low, rotation is frozen.
- `keycode`  in  8  current keycode from the keyboard interface.
- `red_index`  out  6  red ball angle index.
- `blue_index`  out  6  blue ball angle index; always (red_index+HALF) mod STEPS.
- `step_valid`  out  1  one-cycle pulse in the cycle the indices show a new value.
- `step_dir`  out  1  direction of the last step; 1 = CCW, 0 = CW.

## Operation
- **Frame tick:** `frame_clk` passes through a 2-flop synchronizer plus an edge register. `tick` is a one-`Clk` pulse on a synchronized 0→1 edge. No other input is synchronized.
- **Sampling:** `keycode` and `enable` are sampled only in the `tick` cycle. Between ticks, state, counters and indices hold.
- **Key decode:** `KEY_CCW` gives dir=1. `KEY_CW` gives dir=0. Any other value means released.
- **FSM states:** IDLE, SLOW, FAST. Registers: `frame_cnt` (0..SLOW_DIV−1), `hold_cnt` (saturates at HOLD_FRAMES), `cur_dir`.
- **On a tick with `enable`=0:** go to IDLE, clear counters, no step.
- **IDLE:**
  - Released: stay in IDLE.
  - Key pressed: step once in the key direction, `cur_dir`←dir, go to SLOW, `frame_cnt`←0, `hold_cnt`←1.
- **SLOW, same key held:**
  - If `frame_cnt`==SLOW_DIV−1: step and set `frame_cnt`←0. Otherwise `frame_cnt`++.
  - `hold_cnt`++.
  - If the new `hold_cnt`==HOLD_FRAMES, go to FAST. The step decision for that tick still uses the SLOW rule.
- **FAST, same key held:** step on every tick.
- **Direction reversal (SLOW or FAST, opposite key):** treat exactly as a fresh IDLE press, i.e. immediate step in the new direction, go to SLOW, counters restart.
- **Release (SLOW or FAST):** go to IDLE, clear counters, no step.
- **Step arithmetic:**
  - CCW: `red_index`←(red_index==STEPS−1) ? 0 : red_index+1.
  - CW: `red_index`←(red_index==0) ? STEPS−1 : red_index−1.
  - `blue_index` is registered and updated in the same cycle from the same rule applied to its own value. The invariant blue==(red+HALF) mod STEPS must never break, including across the 59↔0 wrap.
- `step_dir` updates only on a step and holds otherwise.

## Timing
- **Reset (`Reset`=0 at a `Clk` edge):** `red_index`=0, `blue_index`=30, `step_valid`=0, `step_dir`=0, state IDLE, counters 0, synchronizer and edge flops 0.
- **Reset mid-operation:** takes effect on the next edge and overrides any `tick`. The first tick after reset release requires a fresh synchronized 0→1 edge. A `frame_clk` that was already high produces no tick.
- **Latency:** `frame_clk` rise → `tick` is 2–3 `Clk` cycles, synchronizer-dependent. `tick` cycle → indices and `step_valid` is exactly 1 cycle. `step_valid` is high for exactly one cycle and never high in two consecutive cycles.
- **Consumer guarantee:** indices are stable for at least one full frame minus 4 `Clk` cycles before the next `frame_clk` rise. The ball stage sees a settled index.
- **Steady-state step rate:**
  - SLOW: one step per SLOW_DIV frames after the initial immediate step.
  - FAST: one step per frame.
  - Worst case: HOLD_FRAMES−1 frames in SLOW before the FAST transition.
- **Simultaneous events:** `enable`=0 and a key on the same tick resolve to IDLE with no step. A reversal and the HOLD_FRAMES threshold on the same tick resolve to the reversal, so the state goes to SLOW.

## Test plan
- **Reset:** `Reset`=0 for 3 cycles, then 1 with `keycode`=0 for 5 frames → red=0, blue=30, `step_valid` never asserted.
- **Single tap CCW:** `keycode`=4 for one frame, then 0 → exactly one `step_valid` pulse, red=1, blue=31, `step_dir`=1, state returns to IDLE.
- **Wrap CW:** from reset, hold `keycode`=7 for 1 frame → red=59, blue=29. Continue holding until red reaches 58. Steps must occur on frames 1, 5, 9, …
- **Hold acceleration:** hold `keycode`=4 for 20 frames from reset.
  - Steps on frames 1, 5, 9 (SLOW).
  - FAST entered after frame 12; steps on every frame 13–20.
  - Final red = 3 + 8 = 11, blue = 41.
  - `blue − red` = 30 mod 60 checked on every `step_valid`.
- **Reversal:** hold 4 for 14 frames, then 7 on frame 15 → immediate CW step on frame 15 (red decrements by 1), then next CW step on frame 19. No FAST carry-over.
- **Enable and reset interaction:**
  - Hold 4 with `enable`=0 → no steps.
  - Assert `Reset`=0 in the same cycle as a `tick` → reset values, no `step_valid`.
  - `frame_clk` held high across reset release → no tick until the next low→high transition.

Source files
------------

// File: rtl/orbit_index_ctrl.sv
// Keyboard-to-angle controller for the two orbiting balls.
// Samples keycode once per frame and steps the shared circle index.
module orbit_index_ctrl #(
  parameter int          STEPS       = 60,
  parameter int          HALF        = 30,
  parameter int          SLOW_DIV    = 4,
  parameter int          HOLD_FRAMES = 12,
  parameter logic [7:0]  KEY_CCW     = 8'd4,
  parameter logic [7:0]  KEY_CW      = 8'd7
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic [7:0] keycode,
  output logic [5:0] red_index,
  output logic [5:0] blue_index,
  output logic       step_valid,
  output logic       step_dir
);

  localparam int FW = $clog2(SLOW_DIV + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [5:0]    LAST     = 6'(STEPS - 1);
  localparam logic [5:0]    BLUE0    = 6'(HALF);
  localparam logic [FW-1:0] FC_LAST  = FW'(SLOW_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    SLOW,
    FAST
  } state_e;

  function automatic logic [5:0] nxt(input logic [5:0] v, input logic d);
    if (d) return (v == LAST) ? 6'd0 : v + 6'd1;
    else   return (v == 6'd0) ? LAST : v - 6'd1;
  endfunction

  state_e        state_q, state_d;
  logic [FW-1:0] fc_q, fc_d;
  logic [HW-1:0] hold_q, hold_d, hold_nxt;
  logic          dir_q, dir_d;
  logic [5:0]    red_q, red_d, blue_q, blue_d;
  logic          sv_q, sv_d, sd_q, sd_d;
  logic          sync1_q, sync2_q, edge_q;
  logic          valid_q, arm_q, arm_d;
  logic          tick, pressed, key_dir, step;

  // arm_q blocks a tick until the real input has been seen low after reset
  assign arm_d = arm_q | (valid_q & ~sync1_q);
  assign tick  = sync2_q & ~edge_q & arm_q;

  always_comb begin
    state_d  = state_q;
    fc_d     = fc_q;
    hold_d   = hold_q;
    hold_nxt = hold_q;
    dir_d    = dir_q;
    step     = 1'b0;
    pressed  = (keycode == KEY_CCW) || (keycode == KEY_CW);
    key_dir  = (keycode == KEY_CCW);
    if (tick) begin
      if (!enable || !pressed) begin
        state_d = IDLE;
        fc_d    = '0;
        hold_d  = '0;
      end else if (state_q == IDLE || key_dir != dir_q) begin
        step    = 1'b1;
        dir_d   = key_dir;
        state_d = SLOW;
        fc_d    = '0;
        hold_d  = HW'(1);
      end else if (state_q == FAST) begin
        step = 1'b1;
      end else begin
        if (fc_q == FC_LAST) begin
          step = 1'b1;
          fc_d = '0;
        end else begin
          fc_d = fc_q + FW'(1);
        end
        hold_nxt = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        hold_d   = hold_nxt;
        if (hold_nxt == HOLD_MAX) state_d = FAST;
      end
    end
    red_d  = step ? nxt(red_q, key_dir) : red_q;
    blue_d = step ? nxt(blue_q, key_dir) : blue_q;
    sv_d   = step;
    sd_d   = step ? key_dir : sd_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      fc_q    <= '0;
      hold_q  <= '0;
      dir_q   <= 1'b0;
      red_q   <= 6'd0;
      blue_q  <= BLUE0;
      sv_q    <= 1'b0;
      sd_q    <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      valid_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      hold_q  <= hold_d;
      dir_q   <= dir_d;
      red_q   <= red_d;
      blue_q  <= blue_d;
      sv_q    <= sv_d;
      sd_q    <= sd_d;
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      valid_q <= 1'b1;
      arm_q   <= arm_d;
    end
  end

  assign red_index  = red_q;
  assign blue_index = blue_q;
  assign step_valid = sv_q;
  assign step_dir   = sd_q;

endmodule
